// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: word size, opcodes, fetch buffer entry and
// fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: imem request/response, decode-side instruction
// stream and branch redirect. master = fetch unit, slave = its environment.
interface fetch_unit_if;
  import riscv_pkg::*;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // imem_rvalid and redirect are single-cycle strobes with no back-pressure.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, op, funct3, funct7,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, op, funct3, funct7,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t with push/pop/flush.
// Presents a NOP at PC 0 when empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign rdata  = valid ? mem[rd_ptr] : '{pc: '0, instr: NOP_INSTR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // The fetch credit rule guarantees space for every returning response.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && count == FULL_CNT));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, buffer and
// redirect flush. FETCH_PERF_CNT_EN adds fetched/stall performance counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output fetch_state_t dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW+1:0] DEPTH_CNT = (CW + 2)'(FIFO_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  fetch_entry_t    head;
  logic            head_valid;
  logic [CW:0]     count;
  logic [CW+1:0]   occ;
  logic            pop;
  logic            push;
  logic            accept;

  assign pop  = bus.instr_valid && bus.instr_ready;
  assign push = (state == ST_WAIT) && bus.imem_rvalid && !bus.redirect;

  // Occupancy includes the in-flight slot and credits the head being consumed.
  assign occ = {1'b0, count} + (CW + 2)'(state != ST_IDLE) - (CW + 2)'(pop);

  assign bus.imem_req = rst_n && !bus.redirect && (state != ST_DROP) && (occ < DEPTH_CNT) &&
                        ((state == ST_IDLE) || bus.imem_rvalid);
  assign bus.imem_addr = fetch_pc;
  assign accept        = bus.imem_req && bus.imem_ready;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata ('{pc: req_pc, instr: bus.imem_rdata}),
    .rdata (head),
    .valid (head_valid),
    .count (count)
  );

  assign bus.instr_valid = head_valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.op          = head.instr[6:0];
  assign bus.funct3      = head.instr[14:12];
  assign bus.funct7      = head.instr[30];
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
      req_pc   <= {RESET_PC[XLEN-1:2], 2'b00};
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      if (state != ST_IDLE && !bus.imem_rvalid) state <= ST_DROP;
      else                                      state <= ST_IDLE;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
      req_pc   <= fetch_pc;
      state    <= ST_WAIT;
    end else if (bus.imem_rvalid && state != ST_IDLE) begin
      state <= ST_IDLE;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      if (bus.instr_ready && !bus.instr_valid && perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem responder model with variable
// latency, expected-instruction queue, directed scenarios then random traffic.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_state_t dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard and memory model state
  logic [63:0]  exp_q[$];
  logic [31:0]  exp_fpc;
  logic         pend = 1'b0;
  logic [31:0]  pend_addr;
  int           pend_cnt;
  logic         pend_stale;
  int           mem_lat = 1;
  logic         rand_rdy = 1'b0;
  logic         last_req;
  fetch_state_t last_state;
  int           n_pop = 0;
  int           n_stall = 0;

  function automatic logic [31:0] mk_data(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic step(input logic ir, input logic rd, input logic [31:0] rpc);
    logic        deliver;
    logic        accept;
    logic        mem_rdy;
    logic [63:0] e;
    logic [31:0] a;
    @(negedge clk);
    deliver = pend && (pend_cnt == 0);
    mem_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.imem_rvalid = deliver;
    bus.imem_rdata  = deliver ? mk_data(pend_addr) : 32'hDEAD_BEEF;
    bus.imem_ready  = mem_rdy;
    bus.instr_ready = ir;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    #1;
    last_req   = bus.imem_req;
    last_state = dbg_state;
    check("instr_valid", bus.instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("instr_pc", bus.instr_pc, e[63:32]);
      check("instr", bus.instr, e[31:0]);
      check("op", bus.op, e[6:0]);
      check("funct3", bus.funct3, e[14:12]);
      check("funct7", bus.funct7, e[30]);
    end else begin
      check("empty_instr", bus.instr, NOP_INSTR);
      check("empty_pc", bus.instr_pc, 32'h0);
    end
    if (ir && !bus.instr_valid) n_stall++;
    if (bus.instr_valid && ir) begin
      n_pop++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    accept = bus.imem_req && mem_rdy;
    if (rd) check("req_on_redirect", bus.imem_req, 1'b0);
    a = exp_fpc;
    if (accept) begin
      check("imem_addr", bus.imem_addr, a);
      exp_fpc = exp_fpc + 32'd4;
    end
    if (deliver) begin
      if (!pend_stale && !rd) exp_q.push_back({pend_addr, mk_data(pend_addr)});
      pend = 1'b0;
    end else if (pend) begin
      pend_cnt--;
    end
    if (rd) begin
      exp_q.delete();
      exp_fpc = {rpc[31:2], 2'b00};
      if (pend) pend_stale = 1'b1;
    end
    if (accept) begin
      pend       = 1'b1;
      pend_addr  = a;
      pend_cnt   = mem_lat - 1;
      pend_stale = 1'b0;
    end
  endtask

  task automatic do_reset();
    logic stray;
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    #1;
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, NOP_INSTR);
    check("rst_pc", bus.instr_pc, 32'h0);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, RST_PC);
    check("rst_state", dbg_state, ST_IDLE);
    stray = pend;
    pend = 1'b0;
    exp_q.delete();
    exp_fpc = RST_PC;
    n_pop = 0;
    n_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // A response to the abandoned request arrives after reset.
    if (stray) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, RST_PC);
  endtask

  task automatic wait_outstanding();
    for (int i = 0; i < 8; i++) begin
      if (pend && pend_cnt > 0) break;
      step(1'b1, 1'b0, 32'h0);
    end
  endtask

  initial begin
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    do_reset();

    // Zero-wait streaming from RESET_PC
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check("stream_req", last_req, 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

    // Decode back-pressure: requests stop at two in the buffer, head holds
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    check("stall_req", last_req, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect coinciding with consume and response: no DROP, resume at 0x40
    step(1'b1, 1'b1, 32'h0000_0043);
    step(1'b1, 1'b0, 32'h0);
    check("no_drop_state", last_state, ST_IDLE);
    check("redir_req", last_req, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect with a slow response outstanding: that response is dropped
    mem_lat = 3;
    wait_outstanding();
    step(1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b0, 32'h0);
    check("drop_state", last_state, ST_DROP);
    check("drop_req", last_req, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    mem_lat = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

    // Reset while a request is outstanding, late response is stray
    mem_lat = 3;
    wait_outstanding();
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    // Random traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 3);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), $urandom());
    end
    rand_rdy = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    check("perf_fetched", perf_fetched, n_pop);
    check("perf_stall", perf_stall, n_stall);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
